// File: rtl/gps_feed_pacer_pkg.sv
// Shared definitions for the GPS feed pacer: FSM states, input byte layout and FIFO entry width.
package gps_feed_pacer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRIME  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int EOD_BIT  = 7;
    localparam int TOG_BIT  = 6;
    localparam int SIGN_BIT = 2;
    localparam int MAG_LSB  = 0;
    localparam int ENTRY_W  = 3;

endpackage

// File: rtl/gps_sample_fifo.sv
// Single-clock FIFO for {sign, mag} sample entries with occupancy, full and empty flags.
module gps_sample_fifo
    import gps_feed_pacer_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = ENTRY_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] ONE_PTR = 1;
    localparam logic [DEPTH_LOG2:0]   ONE_LVL = 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  wr_en;
    logic                  rd_en;

    // Level can only reach DEPTH = 2**DEPTH_LOG2, so its top bit alone marks full.
    assign full  = level[DEPTH_LOG2];
    assign empty = (level == '0);
    assign dout  = mem[rd_ptr];

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + ONE_PTR;
            if (rd_en) rd_ptr <= rd_ptr + ONE_PTR;
            case ({wr_en, rd_en})
                2'b10:   level <= level + ONE_LVL;
                2'b01:   level <= level - ONE_LVL;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/gps_feed_pacer.sv
// Paces software-written GPS sample bytes out as a steady stream, one sample every CLK_DIV clocks.
module gps_feed_pacer
    import gps_feed_pacer_pkg::*;
#(
    parameter int CLK_DIV         = 3,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int PRIME_LEVEL     = 8,
    parameter int AFULL_LEVEL     = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 gps_data,
    output logic                       sample_valid,
    output logic                       sample_sign,
    output logic [1:0]                 sample_mag,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
    output logic                       afull,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       done,
    output logic [2:0]                 state_dbg
);

    localparam int LW = FIFO_DEPTH_LOG2 + 1;
    localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);
    localparam logic [LW-1:0] AFULL_LVL = LW'(AFULL_LEVEL);
    localparam logic [7:0]    DIV_LAST  = 8'(CLK_DIV - 1);

    state_t               state;
    logic [7:0]           gps_p0;
    logic [7:0]           gps_p1;
    logic                 last_tog;
    logic                 eod_seen;
    logic [7:0]           div_cnt;
    logic                 wr_evt;
    logic                 eod_wr;
    logic                 push;
    logic                 pop;
    logic                 tick;
    logic                 streaming;
    logic [ENTRY_W-1:0]   din;
    logic [ENTRY_W-1:0]   fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 unused_bits;

    assign unused_bits = ^gps_p1[5:3];

    // Stage p0/p1: two-flop capture of the software-driven byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            gps_p0   <= gps_data;
            gps_p1   <= gps_data;
            last_tog <= gps_data[TOG_BIT];
        end else begin
            gps_p0   <= gps_data;
            gps_p1   <= gps_p0;
            last_tog <= gps_p1[TOG_BIT];
        end
    end

    assign wr_evt    = (gps_p1[TOG_BIT] != last_tog);
    assign eod_wr    = wr_evt && gps_p1[EOD_BIT];
    assign push      = wr_evt && !gps_p1[EOD_BIT];
    assign din       = {gps_p1[SIGN_BIT], gps_p1[MAG_LSB +: 2]};
    assign streaming = (state == STREAM) || (state == DRAIN);
    assign tick      = streaming && (div_cnt == DIV_LAST);
    assign pop       = tick && !fifo_empty;

    gps_sample_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .WIDTH      (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign afull     = (fifo_level >= AFULL_LVL);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            div_cnt      <= '0;
            eod_seen     <= 1'b0;
            sample_valid <= 1'b0;
            sample_sign  <= 1'b0;
            sample_mag   <= '0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            done         <= 1'b0;
        end else begin
            sample_valid <= pop;
            if (pop) {sample_sign, sample_mag} <= fifo_dout;
            div_cnt <= (streaming && !tick) ? div_cnt + 8'd1 : 8'd0;
            if (push && fifo_full && !pop) overflow <= 1'b1;
            // Starvation only counts while software is still expected to feed us.
            if (tick && fifo_empty && state == STREAM) underflow <= 1'b1;
            if (eod_wr) eod_seen <= 1'b1;
            case (state)
                IDLE:    if (push) state <= PRIME;
                PRIME:   if (fifo_level >= PRIME_LVL || eod_seen) state <= STREAM;
                STREAM:  if (eod_seen) state <= DRAIN;
                DRAIN: begin
                    if (fifo_empty) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (push) begin
                        state    <= PRIME;
                        done     <= 1'b0;
                        eod_seen <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gps_feed_pacer.sv
// Directed scoreboard bench for gps_feed_pacer: one default instance and one with PRIME_LEVEL = 16.
module tb_gps_feed_pacer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, reset_b;
    logic [7:0] gps_a, gps_b;
    logic       valid_a, sign_a, afull_a, ovf_a, unf_a, done_a;
    logic       valid_b, sign_b, afull_b, ovf_b, unf_b, done_b;
    logic [1:0] mag_a, mag_b;
    logic [4:0] level_a, level_b;
    logic [2:0] state_a, state_b;

    gps_feed_pacer dut_a (
        .clk (clk), .reset (reset_a), .gps_data (gps_a),
        .sample_valid (valid_a), .sample_sign (sign_a), .sample_mag (mag_a),
        .fifo_level (level_a), .afull (afull_a), .overflow (ovf_a),
        .underflow (unf_a), .done (done_a), .state_dbg (state_a)
    );

    gps_feed_pacer #(.PRIME_LEVEL (16)) dut_b (
        .clk (clk), .reset (reset_b), .gps_data (gps_b),
        .sample_valid (valid_b), .sample_sign (sign_b), .sample_mag (mag_b),
        .fifo_level (level_b), .afull (afull_b), .overflow (ovf_b),
        .underflow (unf_b), .done (done_b), .state_dbg (state_b)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [2:0] q_a[$];
    logic [2:0] q_b[$];
    logic [2:0] exp_a, exp_b;
    logic       tog_a, tog_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic [2:0] e, input logic eod, input logic track);
        tog_a = ~tog_a;
        gps_a = {eod, tog_a, 3'b000, e};
        if (track) q_a.push_back(e);
    endtask

    task automatic drive_b(input logic [2:0] e, input logic track);
        tog_b = ~tog_b;
        gps_b = {1'b0, tog_b, 3'b000, e};
        if (track) q_b.push_back(e);
    endtask

    task automatic wait_valid_a(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!valid_a && cyc < 40);
        check("a_valid_seen", 32'(valid_a), 1);
    endtask

    // Scoreboard: every emitted sample must match the oldest outstanding write.
    always @(negedge clk) begin
        if (valid_a) begin
            check("a_sample_expected", 32'(q_a.size() != 0), 1);
            if (q_a.size() != 0) begin
                exp_a = q_a.pop_front();
                check("a_sample_value", {sign_a, mag_a}, exp_a);
            end
        end
        if (valid_b) begin
            check("b_sample_expected", 32'(q_b.size() != 0), 1);
            if (q_b.size() != 0) begin
                exp_b = q_b.pop_front();
                check("b_sample_value", {sign_b, mag_b}, exp_b);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lvl;
        int cyc;
        reset_a = 1'b1; reset_b = 1'b1;
        gps_a = 8'h00; gps_b = 8'h00;
        tog_a = 1'b0; tog_b = 1'b0;
        repeat (3) @(negedge clk);
        check("a_reset_outputs", {valid_a, sign_a, mag_a, level_a, afull_a, ovf_a, unf_a, done_a, state_a}, 0);
        check("b_reset_outputs", {valid_b, sign_b, mag_b, level_b, afull_b, ovf_b, unf_b, done_b, state_b}, 0);
        reset_a = 1'b0; reset_b = 1'b0;

        // Overfill instance B: 17 back-to-back writes, the 17th must be dropped.
        for (int i = 0; i < 20; i++) begin
            lvl = (i < 3) ? 0 : ((i - 2 > 16) ? 16 : i - 2);
            check("b_level", level_b, lvl);
            check("b_afull", afull_b, 32'(lvl >= 12));
            check("b_overflow", ovf_b, 32'(i >= 19));
            if (i < 17) drive_b(3'(i), i < 16);
            @(negedge clk);
        end
        cyc = 0;
        while (q_b.size() != 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("b_queue_drained", q_b.size(), 0);
        repeat (6) @(negedge clk);
        check("b_state_stream", state_b, 2);
        check("b_underflow", unf_b, 1);

        // Instance A: prime with 10 writes, stream, collide a push with a pop at level 4.
        reset_a = 1'b1;
        @(negedge clk);
        reset_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_a((i % 2 == 0) ? 3'b111 : 3'b001, 1'b0, 1'b1);
            @(negedge clk);
        end
        check("a_primed_level", level_a, 8);
        check("a_primed_state", state_a, 1);
        check("a_no_early_sample", q_a.size(), 10);
        for (int k = 0; k < 11; k++) begin
            wait_valid_a(cyc);
            if (k == 0) check("a_first_latency", cyc, 4);
            else        check("a_sample_period", cyc, 3);
            check("a_level_after_pop", level_a, (k <= 5) ? 9 - k : 10 - k);
            if (k == 5) drive_a(3'b010, 1'b0, 1'b1);
        end
        check("a_no_underflow_yet", unf_a, 0);
        repeat (4) @(negedge clk);
        check("a_underflow", unf_a, 1);
        check("a_stream_holds", state_a, 2);
        check("a_queue_empty", q_a.size(), 0);

        // Short file: 5 samples then end-of-data.
        reset_a = 1'b1;
        @(negedge clk);
        reset_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_a(3'(i + 3), 1'b0, 1'b1);
            @(negedge clk);
        end
        drive_a(3'b000, 1'b1, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            wait_valid_a(cyc);
            if (k == 0) begin
                check("a_eod_first_latency", cyc, 6);
                check("a_drain_state", state_a, 3);
            end else begin
                check("a_drain_period", cyc, 3);
            end
        end
        check("a_drained_level", level_a, 0);
        check("a_done_not_yet", done_a, 0);
        @(negedge clk);
        check("a_done", done_a, 1);
        check("a_done_state", state_a, 4);
        drive_a(3'b101, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("a_restart_state", state_a, 1);
        check("a_restart_done", done_a, 0);
        repeat (2) @(negedge clk);
        check("a_eod_cleared", state_a, 1);

        // Reset in the middle of streaming at level 6.
        reset_a = 1'b1;
        @(negedge clk);
        reset_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_a(3'(7 - i), 1'b0, 1'b1);
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) wait_valid_a(cyc);
        check("a_level_before_reset", level_a, 6);
        reset_a = 1'b1;
        @(posedge clk);
        q_a.delete();
        @(negedge clk);
        check("a_midreset_outputs", {valid_a, sign_a, mag_a, level_a, afull_a, ovf_a, unf_a, done_a, state_a}, 0);
        reset_a = 1'b0;
        repeat (8) @(negedge clk);
        check("a_post_reset_level", level_a, 0);
        check("a_post_reset_state", state_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
